// File: rtl/counter_mod10.sv
// One BCD digit of the countdown timer: loadable, enabled mod-10 down-counter with borrow (tc) and empty (zero) flags.
// Optional feature: define COUNTER_MOD10_LOAD_ERR_EN to add the registered load_err output flagging out-of-range loads.
module counter_mod10 #(
  parameter int unsigned RESET_VAL = 0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] data,
  input  logic       loadn,
  input  logic       en,
`ifdef COUNTER_MOD10_LOAD_ERR_EN
  output logic       load_err,
`endif
  output logic [3:0] ones,
  output logic       tc,
  output logic       zero
);

  if (RESET_VAL > 9) begin : g_bad_reset_val
    $error("counter_mod10: RESET_VAL must be 0..9");
  end

  localparam logic [3:0] RESET_ONES = 4'(RESET_VAL);

  // Out-of-range BCD load values saturate to the top digit.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  logic [3:0] ones_d, ones_q;

  always_comb begin
    ones_d = ones_q;
    if (clr) begin
      ones_d = RESET_ONES;
    end else if (!loadn) begin
      ones_d = clamp_bcd(data);
    end else if (en) begin
      ones_d = (ones_q == 4'd0) ? 4'd9 : ones_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    ones_q <= ones_d;
  end

  assign ones = ones_q;
  assign zero = (ones_q == 4'd0);
  // Borrow only when this edge actually performs the 0->9 wrap.
  assign tc   = en & zero & loadn & ~clr;

`ifdef COUNTER_MOD10_LOAD_ERR_EN
  logic load_err_d, load_err_q;

  always_comb begin
    load_err_d = 1'b0;
    if (!clr && !loadn && (data > 4'd9)) begin
      load_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    load_err_q <= load_err_d;
  end

  assign load_err = load_err_q;
`endif

endmodule

// File: tb/tb_counter_mod10.sv
// Directed bench for counter_mod10: reset, load/clamp, hold, decrement/wrap, borrow and priority cases.
module tb_counter_mod10;

  logic       clk = 1'b0;
  logic       clr, loadn, en;
  logic [3:0] data;
  logic [3:0] ones;
  logic       tc, zero;
`ifdef COUNTER_MOD10_LOAD_ERR_EN
  logic       load_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  counter_mod10 #(.RESET_VAL(0)) dut (
    .clk      (clk),
    .clr      (clr),
    .data     (data),
    .loadn    (loadn),
    .en       (en),
`ifdef COUNTER_MOD10_LOAD_ERR_EN
    .load_err (load_err),
`endif
    .ones     (ones),
    .tc       (tc),
    .zero     (zero)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_ones [5] = '{2, 1, 0, 9, 8};
  int exp_tc   [5] = '{0, 0, 0, 1, 0};

  initial begin
    clr = 1'b1; loadn = 1'b1; en = 1'b1; data = 4'd0;
    #2;

    // Reset, with en held high under clr
    tick();
    check("rst_ones", ones, 0);
    check("rst_zero", zero, 1);
    check("rst_tc",   tc,   0);
    tick();
    check("rst_hold_en", ones, 0);

    // Load 6, then hold 20 cycles with en=0
    clr = 1'b0; en = 1'b0; data = 4'd6; loadn = 1'b0;
    tick();
    loadn = 1'b1;
    check("load6", ones, 6);
`ifdef COUNTER_MOD10_LOAD_ERR_EN
    check("load6_err", load_err, 0);
`endif
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold6", ones, 6);
    end
    check("hold6_zero", zero, 0);
    check("hold6_tc",   tc,   0);

    // Load 3 then count down through the wrap
    data = 4'd3; loadn = 1'b0;
    tick();
    loadn = 1'b1; en = 1'b1;
    check("load3", ones, 3);
    for (int i = 0; i < 5; i++) begin
      check("dec_tc", tc, exp_tc[i]);
      tick();
      check("dec_ones", ones, exp_ones[i]);
    end

    // Clamp: 12 loads as 9
    en = 1'b0; data = 4'd12; loadn = 1'b0;
    tick();
    loadn = 1'b1;
    check("clamp12", ones, 9);
`ifdef COUNTER_MOD10_LOAD_ERR_EN
    check("clamp12_err", load_err, 1);
    tick();
    check("clamp12_err_pulse", load_err, 0);
`endif

    // Clamp: 15 loads as 9 (from a different value first)
    data = 4'd2; loadn = 1'b0;
    tick();
    check("load2", ones, 2);
    data = 4'd15;
    tick();
    loadn = 1'b1;
    check("clamp15", ones, 9);

    // Load beats en; tc suppressed while loading from 0
    data = 4'd0; loadn = 1'b0;
    tick();
    en = 1'b1;
    check("load0_tc_masked", tc, 0);
    data = 4'd5;
    tick();
    loadn = 1'b1; en = 1'b0;
    check("load_over_en", ones, 5);

    // clr beats load
    clr = 1'b1; loadn = 1'b0; data = 4'd7; en = 1'b1;
    tick();
    check("clr_over_load", ones, 0);
    check("clr_tc_masked", tc, 0);
    check("clr_zero", zero, 1);

    // Mid-count clear
    clr = 1'b0; data = 4'd5; loadn = 1'b0; en = 1'b0;
    tick();
    loadn = 1'b1; en = 1'b1;
    tick();
    check("mid_ones4", ones, 4);
    clr = 1'b1;
    tick();
    check("mid_clr", ones, 0);
    clr = 1'b0; en = 1'b0;
    tick();
    check("post_clr_hold", ones, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
